// File: rtl/fb_sram_arbiter.sv
// rtl/fb_sram_arbiter.sv - framebuffer SRAM arbiter: VGA absolute priority, rasterizer/CPU round-robin
module fb_sram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  n_rst_async,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic [DATA_WIDTH-1:0] vga_rdata,
    output logic                  vga_rvalid,
    input  logic                  rast_req,
    input  logic [ADDR_WIDTH-1:0] rast_addr,
    input  logic [DATA_WIDTH-1:0] rast_wdata,
    output logic                  rast_gnt,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_we,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    typedef enum logic {
        PREF_RAST = 1'b0,
        PREF_CPU  = 1'b1
    } pref_t;

    pref_t                 rr_pref;
    logic                  tag_vga;
    logic                  tag_cpu;
    logic [DATA_WIDTH-1:0] vga_rdata_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic                  sel_rast;
    logic                  sel_cpu;

    // VGA pre-empts everything; the round-robin preference only matters on a tie.
    always_comb begin
        sel_rast = 1'b0;
        sel_cpu  = 1'b0;
        if (!vga_req) begin
            if (rast_req && cpu_req) begin
                sel_cpu  = (rr_pref == PREF_CPU);
                sel_rast = (rr_pref == PREF_RAST);
            end else begin
                sel_rast = rast_req;
                sel_cpu  = cpu_req;
            end
        end
    end

    assign rast_gnt = sel_rast;
    assign cpu_gnt  = sel_cpu;

    always_comb begin
        sram_addr  = '0;
        sram_we    = 1'b0;
        sram_wdata = '0;
        if (vga_req) begin
            sram_addr = vga_addr;
        end else if (sel_rast) begin
            sram_addr  = rast_addr;
            sram_we    = 1'b1;
            sram_wdata = rast_wdata;
        end else if (sel_cpu) begin
            sram_addr  = cpu_addr;
            sram_we    = cpu_we;
            sram_wdata = cpu_we ? cpu_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            rr_pref     <= PREF_CPU;
            tag_vga     <= 1'b0;
            tag_cpu     <= 1'b0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            if (sel_rast) begin
                rr_pref <= PREF_CPU;
            end else if (sel_cpu) begin
                rr_pref <= PREF_RAST;
            end
            tag_vga <= vga_req;
            tag_cpu <= sel_cpu && !cpu_we;
            if (tag_vga) begin
                vga_rdata_q <= sram_rdata;
            end
            if (tag_cpu) begin
                cpu_rdata_q <= sram_rdata;
            end
        end
    end

    // SRAM data arrives one cycle after the address, so the tag steers it straight through.
    assign vga_rvalid = tag_vga;
    assign cpu_rvalid = tag_cpu;
    assign vga_rdata  = tag_vga ? sram_rdata : vga_rdata_q;
    assign cpu_rdata  = tag_cpu ? sram_rdata : cpu_rdata_q;

endmodule

// File: doc/fb_sram_arbiter.md
Name: fb_sram_arbiter

Overview:
- Shares the single-port framebuffer SRAM in vgacpu_top between three requesters: VGA scanout (read-only), rasterizer (write-only) and CPU (read/write).
- VGA has absolute priority so scanout never stalls. Rasterizer and CPU share the remaining slots round-robin.
- Sits between vga, rasterizer, cpu and inferred_sram. SRAM read latency is 1 cycle (registered read data).

Parameters:
- ADDR_WIDTH, 15, framebuffer word address width.
- DATA_WIDTH, 3, pixel width (R,G,B bits).

Ports:
- clk  in  1  system clock (50 MHz)
- n_rst_async  in  1  asynchronous active-low reset
- vga_req  in  1  VGA read request this cycle
- vga_addr  in  ADDR_WIDTH  VGA read address
- vga_rdata  out  DATA_WIDTH  VGA read data
- vga_rvalid  out  1  vga_rdata valid
- rast_req  in  1  rasterizer write request
- rast_addr  in  ADDR_WIDTH  rasterizer write address
- rast_wdata  in  DATA_WIDTH  rasterizer write data
- rast_gnt  out  1  rasterizer write accepted this cycle
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rdata  out  DATA_WIDTH  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_we  out  1  SRAM write enable
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM registered read data (valid 1 cycle after address)

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst_async is asynchronous and active-low.
- Reset state:
  - rr_pref = CPU (CPU wins first contention).
  - Read tag pipeline cleared.
  - vga_rvalid = cpu_rvalid = 0.
  - vga_rdata = cpu_rdata = 0.
- Grants and sram_* outputs are combinational from the current requests and rr_pref. Only rr_pref and the read tag are registered.
- Grant priority, evaluated each cycle:
  1. vga_req = 1: VGA wins. sram_addr = vga_addr, sram_we = 0, rast_gnt = cpu_gnt = 0.
  2. Otherwise, only rast_req: rasterizer wins.
  3. Otherwise, only cpu_req: CPU wins.
  4. Otherwise, both rast_req and cpu_req: the one indicated by rr_pref wins.
  5. No request: sram_addr = 0, sram_we = 0, sram_wdata = 0, no grant.
- Rasterizer grant: sram_addr = rast_addr, sram_we = 1, sram_wdata = rast_wdata, rast_gnt = 1.
- CPU grant: sram_addr = cpu_addr, sram_we = cpu_we, sram_wdata = cpu_wdata (0 when reading), cpu_gnt = 1.
- rr_pref update at the clock edge: after a rasterizer grant, rr_pref = CPU. After a CPU grant, rr_pref = RAST. Otherwise unchanged. Under sustained contention this gives strict alternation.
- Handshake: a requester holds req, addr and data stable until it sees gnt high at a clock edge. req may drop without a grant (request withdrawn, no side effect). The VGA request needs no grant because it is always served.
- Read tag: registered 2-bit tag {VGA, CPU} set from the grant type in cycle N (VGA, or CPU read). Writes and idle set no tag.
- Read return in cycle N+1:
  - Tag VGA: vga_rvalid = 1, vga_rdata = sram_rdata.
  - Tag CPU: cpu_rvalid = 1, cpu_rdata = sram_rdata.
  - rvalid is a 1-cycle pulse. rdata holds its last value when rvalid = 0.
- Back-to-back reads are fully pipelined: one access per cycle, no bubbles.
- Read-after-write to the same address in consecutive cycles returns the new data, relying on the SRAM write-then-read ordering across cycles.
- Reset asserted mid-operation: pending read tags are discarded, so no rvalid follows reset. rr_pref returns to CPU.
- Starvation: rasterizer and CPU both stall while VGA reads continuously. This is acceptable; scanout leaves blanking intervals free.

Test Plan:
- Reset, then VGA reads addr 0x0010 while SRAM holds 3'b101 there -> next cycle vga_rvalid = 1, vga_rdata = 3'b101. No gnt asserted.
- rast_req with addr 0x0100, data 3'b011, no other requests -> rast_gnt = 1, sram_we = 1 same cycle. A CPU read of 0x0100 two cycles later -> cpu_rvalid with 3'b011.
- rast_req and cpu_req held high for 6 cycles, no VGA, CPU reads -> grants CPU, RAST, CPU, RAST, CPU, RAST. Exactly 3 cpu_rvalid pulses, each 1 cycle after its grant.
- vga_req, rast_req and cpu_req all high for 4 cycles, then vga_req low -> no rast/cpu grant during the 4 cycles. Cycle 5 grants CPU (rr_pref reset value).
- CPU read granted, then n_rst_async pulsed low before the next edge -> cpu_rvalid stays 0. After release, all outputs are 0 and rr_pref = CPU.
- VGA reads alternating with CPU reads every cycle at distinct addresses -> rvalid pulses alternate vga/cpu with matching data and zero bubbles.
